// File: rtl/cluster_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module   : cluster_pwr_seq
// Brief    : Cluster power-up / drain / power-down sequencer, registered outputs
// Revision : 1.0 - initial release
// ============================================================================
module cluster_pwr_seq #(
  parameter int unsigned PWR_CYCLES   = 16,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        on_req_i,
  input  logic        off_req_i,
  input  logic [63:0] boot_addr_i,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o,
  output logic        seq_busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWR_UP = 3'd1,
    S_CLK_UP = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_RST_DN = 3'd5,
    S_PWR_DN = 3'd6
  } state_e;

  localparam logic [15:0] C_PWR_LOAD  = 16'(PWR_CYCLES - 1);
  localparam logic [15:0] C_RST_LOAD  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] C_IDLE_LOAD = 16'(IDLE_TIMEOUT - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [4:0]  ctrl_q;
  logic        done_q;
  logic        timeout_q;
  logic [63:0] boot_q;

  // {pow, clk_en, rstn, fetch, seq_busy} for the state being entered
  function automatic logic [4:0] ctrl_of(state_e s);
    case (s)
      S_PWR_UP: return 5'b10001;
      S_CLK_UP: return 5'b11001;
      S_RUN:    return 5'b11110;
      S_DRAIN:  return 5'b11101;
      S_RST_DN: return 5'b11001;
      S_PWR_DN: return 5'b10001;
      default:  return 5'b00000;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      boot_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_OFF: begin
          if (on_req_i) begin
            state_q   <= S_PWR_UP;
            ctrl_q    <= ctrl_of(S_PWR_UP);
            cnt_q     <= C_PWR_LOAD;
            boot_q    <= boot_addr_i;
            timeout_q <= 1'b0;
          end
        end
        S_PWR_UP: begin
          if (cnt_q == '0) begin
            state_q <= S_CLK_UP;
            ctrl_q  <= ctrl_of(S_CLK_UP);
            cnt_q   <= C_RST_LOAD;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_CLK_UP: begin
          if (cnt_q == '0) begin
            state_q <= S_RUN;
            ctrl_q  <= ctrl_of(S_RUN);
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_RUN: begin
          if (off_req_i) begin
            state_q <= S_DRAIN;
            ctrl_q  <= ctrl_of(S_DRAIN);
            cnt_q   <= C_IDLE_LOAD;
          end
        end
        S_DRAIN: begin
          // An idle cluster always wins over an expiring drain timer
          if (!cluster_busy_i || cnt_q == '0) begin
            state_q <= S_RST_DN;
            ctrl_q  <= ctrl_of(S_RST_DN);
            cnt_q   <= C_RST_LOAD;
            if (cluster_busy_i) begin
              timeout_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_RST_DN: begin
          if (cnt_q == '0) begin
            state_q <= S_PWR_DN;
            ctrl_q  <= ctrl_of(S_PWR_DN);
            cnt_q   <= C_PWR_LOAD;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_PWR_DN: begin
          if (cnt_q == '0) begin
            state_q <= S_OFF;
            ctrl_q  <= ctrl_of(S_OFF);
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= S_OFF;
          ctrl_q  <= ctrl_of(S_OFF);
        end
      endcase
    end
  end

  assign {cluster_pow_o, cluster_clk_en_o, cluster_rstn_o,
          cluster_fetch_enable_o, seq_busy_o} = ctrl_q;
  assign cluster_boot_addr_o = boot_q;
  assign done_o              = done_q;
  assign timeout_o           = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_cluster_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_pwr_seq
// Brief    : Three sequencer configurations under random requests, scoreboarded
//            against a timeline (segment plan) model of the power sequences
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_pwr_seq;

  localparam int NI       = 3;
  localparam int N_CYCLES = 6000;
  localparam int T_OFF = 0, T_PWRUP = 1, T_CLKUP = 2, T_RUN = 3;
  localparam int T_DRAIN = 4, T_RSTDN = 5, T_PWRDN = 6;

  typedef struct packed {
    logic        pow, clk_en, rstn, fetch, sbusy, done, to;
    logic [63:0] boot;
  } vec_t;

  typedef struct {
    int   cyc;
    int   k;
    vec_t v;
  } exp_t;

  logic          clk = 1'b0;
  int            cyc = 0;
  logic [NI-1:0] rst_n, on_req, off_req, busy;
  logic [63:0]   boot_in [NI];
  logic [NI-1:0] pow, clk_en, rstn, fetch, sbusy, done, tmo;
  logic [63:0]   boot_out [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cluster_pwr_seq u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .on_req_i(on_req[0]), .off_req_i(off_req[0]),
    .boot_addr_i(boot_in[0]), .cluster_busy_i(busy[0]), .cluster_pow_o(pow[0]),
    .cluster_clk_en_o(clk_en[0]), .cluster_rstn_o(rstn[0]),
    .cluster_fetch_enable_o(fetch[0]), .cluster_boot_addr_o(boot_out[0]),
    .seq_busy_o(sbusy[0]), .done_o(done[0]), .timeout_o(tmo[0]));

  cluster_pwr_seq #(.IDLE_TIMEOUT(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .on_req_i(on_req[1]), .off_req_i(off_req[1]),
    .boot_addr_i(boot_in[1]), .cluster_busy_i(busy[1]), .cluster_pow_o(pow[1]),
    .cluster_clk_en_o(clk_en[1]), .cluster_rstn_o(rstn[1]),
    .cluster_fetch_enable_o(fetch[1]), .cluster_boot_addr_o(boot_out[1]),
    .seq_busy_o(sbusy[1]), .done_o(done[1]), .timeout_o(tmo[1]));

  cluster_pwr_seq #(.PWR_CYCLES(1), .RST_CYCLES(1), .IDLE_TIMEOUT(3)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .on_req_i(on_req[2]), .off_req_i(off_req[2]),
    .boot_addr_i(boot_in[2]), .cluster_busy_i(busy[2]), .cluster_pow_o(pow[2]),
    .cluster_clk_en_o(clk_en[2]), .cluster_rstn_o(rstn[2]),
    .cluster_fetch_enable_o(fetch[2]), .cluster_boot_addr_o(boot_out[2]),
    .seq_busy_o(sbusy[2]), .done_o(done[2]), .timeout_o(tmo[2]));

  function automatic int pwr_of(int k);
    return (k == 2) ? 1 : 16;
  endfunction
  function automatic int rst_of(int k);
    return (k == 2) ? 1 : 8;
  endfunction
  function automatic int idle_of(int k);
    return (k == 0) ? 1024 : ((k == 1) ? 4 : 3);
  endfunction

  // Output pattern of each sequence phase, straight from the phase table
  function automatic vec_t mk(int tag, logic to, logic [63:0] boot, logic dn);
    vec_t v;
    v.pow    = (tag != T_OFF);
    v.clk_en = (tag == T_CLKUP) || (tag == T_RUN) || (tag == T_DRAIN) || (tag == T_RSTDN);
    v.rstn   = (tag == T_RUN) || (tag == T_DRAIN);
    v.fetch  = (tag == T_RUN);
    v.sbusy  = (tag != T_OFF) && (tag != T_RUN);
    v.done   = dn;
    v.to     = to;
    v.boot   = boot;
    return v;
  endfunction

  // Model: steady OFF/RUN plus a plan of timed segments still to be played out
  vec_t cur_v      [NI];
  int   cur_tag    [NI];
  bit   steady_run [NI];
  vec_t seg_v      [NI][4];
  int   seg_tag    [NI][4];
  int   seg_cnt    [NI][4];
  int   seg_n      [NI];
  int   seg_i      [NI];

  exp_t sb_q    [$];
  int   probe_q [$];
  event probe_ev;
  int   checks   = 0;
  int   failures = 0;

  task automatic add_seg(int k, int tag, int n, logic to, logic [63:0] boot, logic dn);
    seg_v[k][seg_n[k]]   = mk(tag, to, boot, dn);
    seg_tag[k][seg_n[k]] = tag;
    seg_cnt[k][seg_n[k]] = n;
    seg_n[k]++;
  endtask

  task automatic model_reset(int k);
    seg_n[k]      = 0;
    seg_i[k]      = 0;
    steady_run[k] = 1'b0;
    cur_tag[k]    = T_OFF;
    cur_v[k]      = mk(T_OFF, 1'b0, 64'd0, 1'b0);
  endtask

  // Advance one cycle given the inputs sampled at the coming edge; b is the
  // number of drain cycles for which busy will be held high if off is accepted.
  task automatic model_step(int k, logic on, logic off, logic [63:0] bin, int b,
                            output bit off_acc);
    logic to;
    int   len;
    off_acc = 1'b0;
    if (seg_i[k] >= seg_n[k]) begin
      seg_n[k] = 0;
      seg_i[k] = 0;
      if (!steady_run[k] && on) begin
        add_seg(k, T_PWRUP, pwr_of(k), 1'b0, bin, 1'b0);
        add_seg(k, T_CLKUP, rst_of(k), 1'b0, bin, 1'b0);
        add_seg(k, T_RUN,   1,         1'b0, bin, 1'b1);
        steady_run[k] = 1'b1;
      end else if (steady_run[k] && off) begin
        to  = (b >= idle_of(k));
        len = to ? idle_of(k) : b + 1;
        add_seg(k, T_DRAIN, len,       cur_v[k].to, cur_v[k].boot, 1'b0);
        add_seg(k, T_RSTDN, rst_of(k), to,          cur_v[k].boot, 1'b0);
        add_seg(k, T_PWRDN, pwr_of(k), to,          cur_v[k].boot, 1'b0);
        add_seg(k, T_OFF,   1,         to,          cur_v[k].boot, 1'b1);
        steady_run[k] = 1'b0;
        off_acc       = 1'b1;
      end
    end
    if (seg_i[k] < seg_n[k]) begin
      cur_v[k]   = seg_v[k][seg_i[k]];
      cur_tag[k] = seg_tag[k][seg_i[k]];
      seg_cnt[k][seg_i[k]]--;
      if (seg_cnt[k][seg_i[k]] == 0) seg_i[k]++;
    end else begin
      cur_tag[k] = steady_run[k] ? T_RUN : T_OFF;
      cur_v[k]   = mk(cur_tag[k], cur_v[k].to, cur_v[k].boot, 1'b0);
    end
  endtask

  function automatic vec_t got_of(int k);
    vec_t v;
    v.pow    = pow[k];
    v.clk_en = clk_en[k];
    v.rstn   = rstn[k];
    v.fetch  = fetch[k];
    v.sbusy  = sbusy[k];
    v.done   = done[k];
    v.to     = tmo[k];
    v.boot   = boot_out[k];
    return v;
  endfunction

  // Monitor: compares every output of every instance once per cycle, and
  // checks asynchronous-reset probes the instant the driver posts them.
  initial begin
    exp_t e;
    vec_t g;
    int   pk;
    forever begin
      @(negedge clk or probe_ev);
      while (probe_q.size() > 0) begin
        pk = probe_q.pop_front();
        g  = got_of(pk);
        checks++;
        if (g !== '0) begin
          failures++;
          $display("FAIL async_reset inst=%0d cyc=%0d got=%h exp=0", pk, cyc, g);
        end
      end
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        g = got_of(e.k);
        checks++;
        if (e.cyc != cyc) begin
          failures++;
          $display("FAIL stale_entry inst=%0d got_cyc=%0d exp_cyc=%0d", e.k, cyc, e.cyc);
        end else if (g !== e.v) begin
          failures++;
          $display("FAIL outputs inst=%0d cyc=%0d got=%h exp=%h", e.k, cyc, g, e.v);
        end
      end
    end
  end

  // Driver
  initial begin
    int   bleft   [NI];
    bit   armed   [NI];
    int   quiet   [NI];
    bit   rst_clk [NI];
    bit   rst_drn [NI];
    bit   do_rst  [NI];
    bit   any_rst;
    bit   acc;
    int   b;
    exp_t e;

    rst_n   = '0;
    on_req  = '0;
    off_req = '0;
    busy    = '0;
    foreach (boot_in[k]) boot_in[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = '1;
    for (int k = 0; k < NI; k++) begin
      model_reset(k);
      armed[k]   = 1'b0;
      bleft[k]   = 0;
      quiet[k]   = 3;
      rst_clk[k] = 1'b0;
      rst_drn[k] = 1'b0;
      e.cyc = cyc;
      e.k   = k;
      e.v   = cur_v[k];
      sb_q.push_back(e);
    end

    for (int n = 0; n < N_CYCLES; n++) begin
      any_rst = 1'b0;
      for (int k = 0; k < NI; k++) begin
        rst_n[k]  = 1'b1;
        do_rst[k] = 1'b0;
        if (armed[k] && cur_tag[k] != T_DRAIN) armed[k] = 1'b0;
        if (!rst_clk[k] && cur_tag[k] == T_CLKUP) begin
          do_rst[k]  = 1'b1;
          rst_clk[k] = 1'b1;
        end else if (!rst_drn[k] && cur_tag[k] == T_DRAIN) begin
          do_rst[k]  = 1'b1;
          rst_drn[k] = 1'b1;
        end
        if (do_rst[k]) begin
          any_rst    = 1'b1;
          on_req[k]  = 1'b0;
          off_req[k] = 1'b0;
          busy[k]    = 1'b0;
          armed[k]   = 1'b0;
          quiet[k]   = 3;
          model_reset(k);
        end else begin
          on_req[k]  = (quiet[k] == 0) && ($urandom_range(0, 7) == 0);
          off_req[k] = ($urandom_range(0, 7) == 0);
          if (quiet[k] == 0 && $urandom_range(0, 15) == 0) begin
            on_req[k]  = 1'b1;
            off_req[k] = 1'b1;
          end
          if (quiet[k] > 0) quiet[k]--;
          boot_in[k] = {$urandom, $urandom};
          if (armed[k]) begin
            busy[k] = (bleft[k] > 0);
            if (bleft[k] > 0) bleft[k]--;
          end else begin
            busy[k] = ($urandom_range(0, 1) == 1);
          end
          if ($urandom_range(0, 3) == 0) b = idle_of(k) - 1 + int'($urandom_range(0, 2));
          else                           b = int'($urandom_range(0, 4));
          model_step(k, on_req[k], off_req[k], boot_in[k], b, acc);
          if (acc) begin
            armed[k] = 1'b1;
            bleft[k] = b;
          end
        end
        e.cyc = cyc + 1;
        e.k   = k;
        e.v   = cur_v[k];
        sb_q.push_back(e);
      end
      if (any_rst) begin
        #6;
        for (int k = 0; k < NI; k++) if (do_rst[k]) rst_n[k] = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) if (do_rst[k]) probe_q.push_back(k);
        -> probe_ev;
      end
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
